// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// The slave modport is the unit itself; the master modport is the
// surrounding pipeline plus the memory that answers the unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline load/store requests into accesses to a
// single-cycle word-only data memory. Sub-word stores are performed as a
// read-modify-write; loads return sign- or zero-extended little-endian lanes.
// All bus outputs are registered, so no path runs from req_* to mem_*.
module load_store_unit #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;

  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic        mem_write_en_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_write_data_r;

  logic        accept_s;
  logic        misaligned_s;
  logic        err_s;
  logic [31:0] word_addr_s;
  logic [1:0]  lane_s;

  // Pick the addressed byte/half lane out of a word and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of a word with new store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00: res[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = wdata[15:0];
        end else begin
          res[15:0] = wdata[15:0];
        end
      end
      2'b10:   res = wdata;
      default: res = old_word;
    endcase
    return res;
  endfunction

  assign bus.req_ready      = (state_r == IDLE);
  assign bus.resp_valid     = resp_valid_r;
  assign bus.resp_rdata     = resp_rdata_r;
  assign bus.resp_err       = resp_err_r;
  assign bus.mem_write_en   = mem_write_en_r;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.mem_write_data = mem_write_data_r;

  // Classify the incoming request: error check, aligned word address, lane.
  // Misaligned halves/words are aligned down when not reported as errors.
  always_comb begin
    accept_s     = bus.req_valid && (state_r == IDLE);
    misaligned_s = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    err_s        = (bus.req_size == 2'b11) || (ERR_ON_MISALIGN && misaligned_s);
    word_addr_s  = {bus.req_addr[31:2], 2'b00};
    case (bus.req_size)
      2'b00:   lane_s = bus.req_addr[1:0];
      2'b01:   lane_s = {bus.req_addr[1], 1'b0};
      default: lane_s = 2'b00;
    endcase
  end

  // Request sequencer: latches the request and drives memory and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      size_r           <= 2'b00;
      unsigned_r       <= 1'b0;
      lane_r           <= 2'b00;
      wdata_r          <= 32'h0000_0000;
      resp_valid_r     <= 1'b0;
      resp_rdata_r     <= 32'h0000_0000;
      resp_err_r       <= 1'b0;
      mem_write_en_r   <= 1'b0;
      mem_addr_r       <= 32'h0000_0000;
      mem_write_data_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            size_r     <= bus.req_size;
            unsigned_r <= bus.req_unsigned;
            lane_r     <= lane_s;
            wdata_r    <= bus.req_wdata;
            if (err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
              state_r      <= RESP;
            end else if (!bus.req_we) begin
              mem_addr_r <= word_addr_s;
              state_r    <= LOAD;
            end else if (bus.req_size == 2'b10) begin
              mem_addr_r       <= word_addr_s;
              mem_write_en_r   <= 1'b1;
              mem_write_data_r <= bus.req_wdata;
              state_r          <= WRITE;
            end else begin
              mem_addr_r <= word_addr_s;
              state_r    <= RMW_RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          resp_rdata_r <= extract_lane(bus.mem_read_data, size_r, lane_r, unsigned_r);
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          mem_addr_r   <= 32'h0000_0000;
          state_r      <= RESP;
        end
        RMW_RD: begin
          mem_write_data_r <= merge_lane(bus.mem_read_data, wdata_r, size_r, lane_r);
          mem_write_en_r   <= 1'b1;
          state_r          <= WRITE;
        end
        WRITE: begin
          mem_write_en_r   <= 1'b0;
          mem_addr_r       <= 32'h0000_0000;
          mem_write_data_r <= 32'h0000_0000;
          resp_valid_r     <= 1'b1;
          resp_err_r       <= 1'b0;
          resp_rdata_r     <= 32'h0000_0000;
          state_r          <= RESP;
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          state_r      <= IDLE;
        end
        default: begin
          resp_valid_r     <= 1'b0;
          resp_err_r       <= 1'b0;
          resp_rdata_r     <= 32'h0000_0000;
          mem_write_en_r   <= 1'b0;
          mem_addr_r       <= 32'h0000_0000;
          mem_write_data_r <= 32'h0000_0000;
          state_r          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a word RAM with switches at 0x90 and an LED
// register at 0x94 answers two units (misalign-error and align-down flavours);
// directed and random requests are checked against an arithmetic model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  switches;
  logic [31:0] leds;
  logic        mem_clear;

  logic [31:0] ram [64];
  logic [31:0] model_ram [64];
  logic [31:0] model_leds;

  int          n_tests;
  int          n_fail;
  int          wr_total;
  int          resp_total;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  load_store_unit_if bus0 ();
  load_store_unit_if bus1 ();

  load_store_unit #(.ERR_ON_MISALIGN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  load_store_unit #(.ERR_ON_MISALIGN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.req_valid    = req_valid && !sel;
  assign bus1.req_valid    = req_valid && sel;
  assign bus0.req_we       = req_we;
  assign bus1.req_we       = req_we;
  assign bus0.req_size     = req_size;
  assign bus1.req_size     = req_size;
  assign bus0.req_unsigned = req_unsigned;
  assign bus1.req_unsigned = req_unsigned;
  assign bus0.req_addr     = req_addr;
  assign bus1.req_addr     = req_addr;
  assign bus0.req_wdata    = req_wdata;
  assign bus1.req_wdata    = req_wdata;

  assign bus0.mem_read_data = (bus0.mem_addr[7:0] == 8'h90) ? {24'h000000, switches}
                                                            : ram[bus0.mem_addr[7:2]];
  assign bus1.mem_read_data = (bus1.mem_addr[7:0] == 8'h90) ? {24'h000000, switches}
                                                            : ram[bus1.mem_addr[7:2]];

  logic        rv_m;
  logic        ready_m;
  logic        err_m;
  logic [31:0] rdata_m;
  assign rv_m    = sel ? bus1.resp_valid : bus0.resp_valid;
  assign ready_m = sel ? bus1.req_ready  : bus0.req_ready;
  assign err_m   = sel ? bus1.resp_err   : bus0.resp_err;
  assign rdata_m = sel ? bus1.resp_rdata : bus0.resp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0103_0507) ^ 32'hA5C3_0F1E;
  endfunction

  // Memory and LED register behaviour on the write edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      leds <= 32'h0;
    end else begin
      if (bus0.mem_write_en) begin
        ram[bus0.mem_addr[7:2]] <= bus0.mem_write_data;
        if (bus0.mem_addr[7:0] == 8'h94) leds <= bus0.mem_write_data;
      end
      if (bus1.mem_write_en) begin
        ram[bus1.mem_addr[7:2]] <= bus1.mem_write_data;
        if (bus1.mem_addr[7:0] == 8'h94) leds <= bus1.mem_write_data;
      end
    end
  end

  // Bus monitor: counts write pulses and response pulses.
  always @(negedge clk) begin
    if (bus0.mem_write_en || bus1.mem_write_en) begin
      wr_total     <= wr_total + 1;
      last_wr_addr <= bus0.mem_write_en ? bus0.mem_addr : bus1.mem_addr;
      last_wr_data <= bus0.mem_write_en ? bus0.mem_write_data : bus1.mem_write_data;
    end
    if (bus0.resp_valid || bus1.resp_valid) resp_total <= resp_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on the selected unit, checked against the reference model.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    logic        mis, exp_err;
    logic [31:0] ea, wa, off, rd, sh, v, mask, nw;
    int          exp_lat, exp_wr, lat, w0;
    logic        seen, got_err;
    logic [31:0] got_rdata;

    mis     = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr % 4 != 0));
    exp_err = (size == 2'd3) || (!sel && mis);
    if (size == 2'd1)      ea = addr - (addr % 2);
    else if (size == 2'd2) ea = addr - (addr % 4);
    else                   ea = addr;
    wa  = ea - (ea % 4);
    off = ea % 4;
    rd  = (wa == 32'h90) ? {24'h0, switches} : model_ram[(wa / 4) % 64];
    v = 32'h0; nw = 32'h0; exp_wr = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      sh = rd >> (8 * off);
      if (size == 2'd0) begin
        v = sh % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = sh % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
        v = rd;
      end
    end else begin
      exp_wr = 1;
      if (size == 2'd2) begin
        exp_lat = 2;
        nw = wdata;
      end else begin
        exp_lat = 3;
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
        nw   = (rd & ~mask) | ((wdata & ((size == 2'd0) ? 32'hFF : 32'hFFFF)) << (8 * off));
      end
    end

    @(negedge clk);
    check_eq("ready_idle", {31'd0, ready_m}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w0 = wr_total;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom % 2; req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_unsigned = $urandom % 2;
    seen = 1'b0; lat = 0; got_err = 1'b0; got_rdata = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rv_m) begin
        seen = 1'b1; lat = k; got_err = err_m; got_rdata = rdata_m;
        break;
      end
    end
    check_eq("resp_seen", {31'd0, seen}, 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_err", {31'd0, got_err}, {31'd0, exp_err});
    check_eq("resp_rdata", got_rdata, v);
    @(negedge clk);
    check_eq("resp_one_cycle", {31'd0, rv_m}, 32'd0);
    check_eq("write_pulses", 32'(wr_total - w0), 32'(exp_wr));
    if (exp_wr == 1) begin
      check_eq("write_addr", last_wr_addr, wa);
      check_eq("write_data", last_wr_data, nw);
      model_ram[(wa / 4) % 64] = nw;
      if (wa == 32'h94) model_leds = nw;
    end
    got = got_rdata;
  endtask

  logic [31:0] got;
  int          w0, r0, acc;

  initial begin
    n_tests = 0; n_fail = 0; wr_total = 0; resp_total = 0;
    last_wr_addr = 32'h0; last_wr_data = 32'h0;
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    switches = 8'h00; model_leds = 32'h0;
    for (int i = 0; i < 64; i++) model_ram[i] = init_word(i);
    rst_n = 1'b0; mem_clear = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, bus0.req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
    check_eq("rst_resp_rdata", bus0.resp_rdata, 32'd0);
    check_eq("rst_resp_err", {31'd0, bus0.resp_err}, 32'd0);
    check_eq("rst_mem_we", {31'd0, bus0.mem_write_en}, 32'd0);
    check_eq("rst_mem_addr", bus0.mem_addr, 32'd0);
    check_eq("rst_mem_wdata", bus0.mem_write_data, 32'd0);
    mem_clear = 1'b0; rst_n = 1'b1;

    // Word store/load and lane extraction.
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h80FF_7F01, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got); check_eq("lw40", got, 32'h80FF_7F01);
    do_req(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, got); check_eq("lb41", got, 32'h0000_007F);
    do_req(1'b0, 2'd0, 1'b0, 32'h42, 32'h0, got); check_eq("lb42", got, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd0, 1'b1, 32'h42, 32'h0, got); check_eq("lbu42", got, 32'h0000_00FF);
    do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, got); check_eq("lh42", got, 32'hFFFF_80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, got); check_eq("lhu42", got, 32'h0000_80FF);
    // Sub-word stores.
    do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AA, got);
    check_eq("sb41_word", ram[16], 32'h80FF_AA01);
    do_req(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_1234, got);
    check_eq("sh42_word", ram[16], 32'h1234_AA01);
    // Misalignment and illegal size.
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, got);
    do_req(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000_BEEF, got);
    check_eq("sh41_unchanged", ram[16], 32'h1234_AA01);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, got);
    // Switches and LEDs.
    switches = 8'hA5;
    do_req(1'b0, 2'd2, 1'b0, 32'h90, 32'h0, got); check_eq("lw90", got, 32'h0000_00A5);
    do_req(1'b0, 2'd0, 1'b1, 32'h90, 32'h0, got); check_eq("lbu90", got, 32'h0000_00A5);
    do_req(1'b1, 2'd2, 1'b0, 32'h94, 32'h0000_003C, got);
    check_eq("leds", leds, 32'h0000_003C);

    // req_valid held high: one acceptance per two cycles for error requests.
    @(negedge clk);
    r0 = resp_total; acc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      if (ready_m) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("b2b_accepts", 32'(acc), 32'd4);
    check_eq("b2b_resps", 32'(resp_total - r0), 32'd4);

    // Reset in the middle of a read-modify-write.
    @(negedge clk);
    w0 = wr_total; r0 = resp_total;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h40; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_ready", {31'd0, bus0.req_ready}, 32'd1);
    check_eq("abort_mem_we", {31'd0, bus0.mem_write_en}, 32'd0);
    check_eq("abort_mem_addr", bus0.mem_addr, 32'd0);
    check_eq("abort_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort_no_write", 32'(wr_total - w0), 32'd0);
    check_eq("abort_no_resp", 32'(resp_total - r0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got); check_eq("abort_word", got, 32'h1234_AA01);

    // Align-down flavour.
    sel = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, got); check_eq("al_lw42", got, 32'h1234_AA01);
    do_req(1'b1, 2'd1, 1'b0, 32'h43, 32'h0000_5678, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got); check_eq("al_word", got, 32'h5678_AA01);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, got);

    // Randomized traffic on both units.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      @(negedge clk);
      sel = (n >= 260);
      if ($urandom % 8 == 0) switches = 8'($urandom);
      sz = 2'($urandom);
      a  = $urandom % 256;
      if ($urandom % 3 != 0) begin
        if (sz == 2'd1) a = a - (a % 2);
        if (sz == 2'd2) a = a - (a % 4);
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, got);
    end

    for (int i = 0; i < 64; i++) check_eq("ram_final", ram[i], model_ram[i]);
    check_eq("leds_final", leds, model_leds);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
